// File: rtl/user_input_entry_pkg.sv
// Shared types and constants for the hex-nibble user input entry block.
package user_input_entry_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NIBBLES = 4;

endpackage

// File: rtl/user_input_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-count debouncer and
// one-cycle rising-edge pulse, armed only after a confirmed release.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clkin,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic          armed;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          if (!sync2) armed <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (!armed && !level) begin
        // After reset a button must be seen released for the full window
        // before its next press is allowed to produce a pulse.
        if (cnt == LAST) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_d & armed;

endmodule

// File: rtl/user_input_entry.sv
// Assembles the 16-bit display/input word one hex nibble per button press and
// offers the complete word over a valid/ack handshake.
module user_input_entry
  import user_input_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        entry_ack,
  output logic [15:0] inpreg,
  output logic [2:0]  nibble_count,
  output logic        entry_valid
);

  logic        enter_p, clear_p;
  logic [3:0]  sw_sync1, sw_sync2;
  state_t      state, state_n;
  logic [15:0] inpreg_n;
  logic [2:0]  count_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clkin (clkin),
    .reset (reset),
    .btn   (btn_enter),
    .pulse (enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clkin (clkin),
    .reset (reset),
    .btn   (btn_clear),
    .pulse (clear_p)
  );

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sw_sync1     <= '0;
      sw_sync2     <= '0;
      state        <= ENTRY;
      inpreg       <= '0;
      nibble_count <= '0;
    end else begin
      sw_sync1     <= sw;
      sw_sync2     <= sw_sync1;
      state        <= state_n;
      inpreg       <= inpreg_n;
      nibble_count <= count_n;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    inpreg_n = inpreg;
    count_n  = nibble_count;
    if (clear_p) begin
      state_n  = ENTRY;
      inpreg_n = '0;
      count_n  = '0;
    end else begin
      case (state)
        ENTRY: begin
          if (enter_p) begin
            inpreg_n = {inpreg[11:0], sw_sync2};
            count_n  = nibble_count + 3'd1;
            if (nibble_count == 3'(NIBBLES - 1)) state_n = FULL;
          end
        end
        FULL: begin
          // Word stays on display after acceptance; only the count restarts.
          if (entry_ack) begin
            state_n = ENTRY;
            count_n = '0;
          end
        end
        default: state_n = ENTRY;
      endcase
    end
  end

  assign entry_valid = (state == FULL);

endmodule

// File: tb/tb_user_input_entry.sv
// Scoreboard bench for user_input_entry: stimulus pushes expected output
// tuples, a negedge monitor pops one per observed output change.
module tb_user_input_entry;

  logic        clkin = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic        btn_enter, btn_clear, entry_ack;
  logic [15:0] inpreg;
  logic [2:0]  nibble_count;
  logic        entry_valid;

  typedef logic [19:0] tup_t;   // {inpreg, nibble_count, entry_valid}

  tup_t        sb[$];
  tup_t        prev, mon_cur, mon_exp;
  bit          mon_en;
  int          tests, fails;

  logic [15:0] m_reg;
  int          m_cnt;
  bit          m_full;
  tup_t        m_last;

  user_input_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clkin        (clkin),
    .reset        (reset),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .entry_ack    (entry_ack),
    .inpreg       (inpreg),
    .nibble_count (nibble_count),
    .entry_valid  (entry_valid)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clkin) begin
    if (mon_en) begin
      mon_cur = {inpreg, nibble_count, entry_valid};
      if (mon_cur !== prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_change: got %h expected %h", mon_cur, prev);
        end else begin
          mon_exp = sb.pop_front();
          check("scoreboard", 32'(mon_cur), 32'(mon_exp));
        end
        prev = mon_cur;
      end
    end
  end

  // Reference model: word as an integer, count as a plain number.
  task automatic model_push();
    tup_t t;
    t = {m_reg, 3'(m_cnt), m_full};
    if (t !== m_last) begin
      sb.push_back(t);
      m_last = t;
    end
  endtask

  task automatic model_reset();
    m_reg  = 16'h0;
    m_cnt  = 0;
    m_full = 1'b0;
    m_last = '0;
    sb.delete();
  endtask

  task automatic model_enter(input logic [3:0] v);
    if (!m_full) begin
      m_reg = 16'((m_reg * 16) + v);
      m_cnt = m_cnt + 1;
      m_full = (m_cnt == 4);
    end
    model_push();
  endtask

  task automatic model_clear();
    m_reg  = 16'h0;
    m_cnt  = 0;
    m_full = 1'b0;
    model_push();
  endtask

  task automatic model_ack();
    if (m_full) begin
      m_full = 1'b0;
      m_cnt  = 0;
    end
    model_push();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    tick(5);
  endtask

  task automatic press_enter(input logic [3:0] v, input int hold, input int rel);
    model_enter(v);
    sw = v;
    tick(1);
    btn_enter = 1'b1;
    tick(hold);
    btn_enter = 1'b0;
    tick(rel);
    wait_drain();
  endtask

  task automatic press_clear(input int hold, input int rel);
    model_clear();
    btn_clear = 1'b1;
    tick(hold);
    btn_clear = 1'b0;
    tick(rel);
    wait_drain();
  endtask

  task automatic press_both(input logic [3:0] v);
    model_clear();
    sw = v;
    tick(1);
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(12);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(12);
    wait_drain();
  endtask

  task automatic send_ack();
    model_ack();
    entry_ack = 1'b1;
    tick(1);
    entry_ack = 1'b0;
    tick(2);
    wait_drain();
  endtask

  task automatic bouncy_enter(input logic [3:0] v, input int n);
    model_enter(v);
    sw = v;
    tick(1);
    for (int k = 0; k < n; k++) begin
      btn_enter = 1'b1;
      tick($urandom_range(1, 3));
      btn_enter = 1'b0;
      tick($urandom_range(1, 3));
    end
    btn_enter = 1'b1;
    tick(10);
    btn_enter = 1'b0;
    tick(12);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    sw = 4'h0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    entry_ack = 1'b0;
    model_reset();
    tick(3);
    check("reset_inpreg", 32'(inpreg), 32'h0);
    check("reset_count", 32'(nibble_count), 32'h0);
    check("reset_valid", 32'(entry_valid), 32'h0);
    reset = 1'b0;
    prev = '0;
    mon_en = 1'b1;
    tick(10);

    // Full entry
    press_enter(4'hA, 10, 12);
    press_enter(4'hB, 10, 12);
    press_enter(4'hC, 10, 12);
    press_enter(4'hD, 10, 12);
    check("full_inpreg", 32'(inpreg), 32'hABCD);
    check("full_count", 32'(nibble_count), 32'd4);
    check("full_valid", 32'(entry_valid), 32'd1);

    // Handshake
    press_enter(4'h5, 10, 12);
    send_ack();
    check("ack_inpreg", 32'(inpreg), 32'hABCD);
    press_enter(4'h1, 10, 12);
    check("after_ack_inpreg", 32'(inpreg), 32'hBCD1);

    // Clear, then clear racing enter
    press_clear(10, 12);
    press_enter(4'h1, 10, 12);
    press_enter(4'h2, 10, 12);
    check("two_nibbles", 32'(inpreg), 32'h0012);
    press_clear(10, 12);
    press_both(4'h7);
    check("both_from_zero", 32'(inpreg), 32'h0);
    press_enter(4'h3, 10, 12);
    press_both(4'h7);
    check("both_from_one", 32'(inpreg), 32'h0);

    // Bounce rejection and long hold
    model_enter(4'h9);
    sw = 4'h9;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      btn_enter = 1'b1;
      tick(2);
      btn_enter = 1'b0;
      tick(2);
    end
    btn_enter = 1'b1;
    tick(10);
    check("bounce_pending", 32'(sb.size()), 32'd0);
    tick(100);
    btn_enter = 1'b0;
    tick(12);
    wait_drain();
    check("bounce_count", 32'(nibble_count), 32'd1);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5)      press_enter(4'($urandom), $urandom_range(8, 20), $urandom_range(10, 15));
      else if (op == 6) press_clear($urandom_range(8, 20), $urandom_range(10, 15));
      else if (op <= 8) send_ack();
      else              bouncy_enter(4'($urandom), $urandom_range(1, 4));
    end

    // Reset in the middle of a debounce with three nibbles entered
    press_clear(10, 12);
    press_enter(4'h4, 10, 12);
    press_enter(4'h5, 10, 12);
    press_enter(4'h6, 10, 12);
    check("pre_reset_count", 32'(nibble_count), 32'd3);
    mon_en = 1'b0;
    sw = 4'h8;
    btn_enter = 1'b1;
    tick(4);
    #3 reset = 1'b1;
    #1;
    check("async_reset_inpreg", 32'(inpreg), 32'h0);
    check("async_reset_count", 32'(nibble_count), 32'h0);
    check("async_reset_valid", 32'(entry_valid), 32'h0);
    tick(2);
    reset = 1'b0;
    model_reset();
    prev = '0;
    mon_en = 1'b1;
    tick(30);
    btn_enter = 1'b0;
    tick(12);
    check("held_no_pulse", 32'(nibble_count), 32'd0);
    press_enter(4'h9, 10, 12);
    check("post_reset_inpreg", 32'(inpreg), 32'h0009);

    tick(20);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
